// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the systolic matrix multiplier operand path.
//   DEF_*       : default element width, matrix shape and skew
//   state_e     : operand stream controller states
//   stream_len  : number of output steps for one skewed matrix stream
//   idx_w       : index width for a dimension, never narrower than one bit
package matmul_pkg;

    localparam int unsigned DEF_BITS = 8;
    localparam int unsigned DEF_ROWS = 8;
    localparam int unsigned DEF_COLS = 8;
    localparam int unsigned DEF_SKEW = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int unsigned stream_len(input int unsigned rows,
                                               input int unsigned cols,
                                               input int unsigned skew);
        return cols + skew * (rows - 1);
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// One ROWS x COLS element store with synchronous clear, a single write port
// and a combinational read of one element per row at per-row column indices.
//   clk, rst          : clock, synchronous active-high clear of all storage
//   wr_en/row/col/data: element write; out-of-range indices are dropped
//   rd_col            : column index requested for each row
//   rd_data_c         : element at [r][rd_col[r]] (0 when the index is out of range)
module matrix_bank
    import matmul_pkg::*;
#(
    parameter  int unsigned BITS = DEF_BITS,
    parameter  int unsigned ROWS = DEF_ROWS,
    parameter  int unsigned COLS = DEF_COLS,
    localparam int unsigned RW   = idx_w(ROWS),
    localparam int unsigned CW   = idx_w(COLS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [RW-1:0]                  wr_row,
    input  logic [CW-1:0]                  wr_col,
    input  logic [BITS-1:0]                wr_data,
    input  logic [ROWS-1:0][CW-1:0]        rd_col,
    output logic [ROWS-1:0][BITS-1:0]      rd_data_c
);

    logic [BITS-1:0] mem [ROWS][COLS];
    logic            wr_hit_c;

    assign wr_hit_c = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

    // Storage: full clear on reset, otherwise single-element write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_hit_c) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Per-row read at independent column positions.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (32'(rd_col[r]) < COLS) begin
                rd_data_c[r] = mem[r][rd_col[r]];
            end
        end
    end

endmodule

// File: rtl/matrix_a_skew_buffer.sv
// Ping-pong staging buffer for the A operand of the systolic array. The host
// fills one bank while the other streams out column by column, with row r
// optionally delayed r*SKEW steps so q feeds the array's west edge directly.
//   wr_en/wr_row/wr_col/wr_data : element write into the current write bank
//   wr_commit                   : mark write bank full and move to the other bank
//   wr_ready                    : write bank is empty (combinational)
//   rd_start                    : begin streaming the oldest full bank
//   rd_en                       : advance the stream; low holds the outputs
//   q, q_valid                  : registered per-row element and lane-valid
//   rd_busy, rd_done            : stream active / final step being presented
module matrix_a_skew_buffer
    import matmul_pkg::*;
#(
    parameter  int unsigned BITS = DEF_BITS,
    parameter  int unsigned ROWS = DEF_ROWS,
    parameter  int unsigned COLS = DEF_COLS,
    parameter  int unsigned SKEW = DEF_SKEW,
    localparam int unsigned RW   = idx_w(ROWS),
    localparam int unsigned CW   = idx_w(COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [RW-1:0]             wr_row,
    input  logic [CW-1:0]             wr_col,
    input  logic [BITS-1:0]           wr_data,
    input  logic                      wr_commit,
    output logic                      wr_ready,
    input  logic                      rd_start,
    input  logic                      rd_en,
    output logic [ROWS-1:0][BITS-1:0] q,
    output logic [ROWS-1:0]           q_valid,
    output logic                      rd_busy,
    output logic                      rd_done
);

    localparam int unsigned LEN = stream_len(ROWS, COLS, SKEW);
    localparam int unsigned SW  = idx_w(LEN + 1);

    state_e                    state, state_nxt;
    logic [SW-1:0]             step, step_nxt;
    logic [1:0]                full, full_nxt;
    logic                      wr_ptr, rd_ptr;
    logic [ROWS-1:0][BITS-1:0] q_nxt;
    logic [ROWS-1:0]           q_valid_nxt;
    logic                      rd_busy_nxt, rd_done_nxt;
    logic                      free_c, commit_c;
    logic [1:0]                bank_we_c;
    logic [ROWS-1:0][CW-1:0]   lane_col_c;
    logic [ROWS-1:0]           lane_v_c;
    logic [ROWS-1:0][BITS-1:0] bank0_data_c, bank1_data_c, rd_data_c;

    assign wr_ready     = !full[wr_ptr];
    assign commit_c     = wr_commit && wr_ready;
    assign bank_we_c[0] = wr_en && wr_ready && !wr_ptr;
    assign bank_we_c[1] = wr_en && wr_ready &&  wr_ptr;
    assign rd_data_c    = rd_ptr ? bank1_data_c : bank0_data_c;

    matrix_bank #(.BITS(BITS), .ROWS(ROWS), .COLS(COLS)) u_bank0 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_we_c[0]),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .rd_col    (lane_col_c),
        .rd_data_c (bank0_data_c)
    );

    matrix_bank #(.BITS(BITS), .ROWS(ROWS), .COLS(COLS)) u_bank1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (bank_we_c[1]),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .rd_col    (lane_col_c),
        .rd_data_c (bank1_data_c)
    );

    // Diagonal skew: row r reads column (step - r*SKEW) when that lies inside the row.
    always_comb begin
        lane_col_c = '0;
        lane_v_c   = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if ((32'(step) >= r * SKEW) && (32'(step) - r * SKEW < COLS)) begin
                lane_v_c[r]   = 1'b1;
                lane_col_c[r] = CW'(32'(step) - r * SKEW);
            end
        end
    end

    // Bank occupancy: a commit and a reader free never hit the same bank,
    // since a commit needs an empty bank and a free needs a full one.
    always_comb begin
        full_nxt = full;
        if (commit_c) full_nxt[wr_ptr] = 1'b1;
        if (free_c)   full_nxt[rd_ptr] = 1'b0;
    end

    // Stream controller: next state and next output register values.
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        q_nxt       = q;
        q_valid_nxt = q_valid;
        rd_busy_nxt = rd_busy;
        rd_done_nxt = rd_done;
        free_c      = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start && full[rd_ptr]) begin
                    state_nxt   = STREAM;
                    step_nxt    = '0;
                    rd_busy_nxt = 1'b1;
                end
            end
            STREAM: begin
                if (rd_en) begin
                    if (step == SW'(LEN)) begin
                        // Edge after the final step: release the bank and go idle.
                        state_nxt   = IDLE;
                        q_nxt       = '0;
                        q_valid_nxt = '0;
                        rd_busy_nxt = 1'b0;
                        rd_done_nxt = 1'b0;
                        free_c      = 1'b1;
                    end else begin
                        for (int unsigned r = 0; r < ROWS; r++) begin
                            q_nxt[r] = lane_v_c[r] ? rd_data_c[r] : '0;
                        end
                        q_valid_nxt = lane_v_c;
                        rd_done_nxt = (step == SW'(LEN - 1));
                        step_nxt    = step + SW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointers and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step    <= '0;
            full    <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            q       <= '0;
            q_valid <= '0;
            rd_busy <= 1'b0;
            rd_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            full    <= full_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            rd_busy <= rd_busy_nxt;
            rd_done <= rd_done_nxt;
            if (commit_c) wr_ptr <= ~wr_ptr;
            if (free_c)   rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: tb/tb_matrix_a_skew_buffer.sv
// Bench for matrix_a_skew_buffer: a SKEW=1 and a SKEW=0 instance (4x4, 8-bit)
// share one directed stimulus; a frame-list model predicts both every cycle,
// and literal expectations pin key steps.
module tb_matrix_a_skew_buffer;

    logic       clk = 1'b0;
    logic       rst, wr_en, wr_commit, rd_start, rd_en;
    logic [1:0] wr_row, wr_col;
    logic [7:0] wr_data;

    logic [3:0][7:0] dq [2];
    logic [3:0]      dv [2];
    logic [1:0]      dbusy, ddone, dready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    matrix_a_skew_buffer #(.BITS(8), .ROWS(4), .COLS(4), .SKEW(1)) u_dut_skew (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .wr_commit(wr_commit), .wr_ready(dready[0]),
        .rd_start(rd_start), .rd_en(rd_en), .q(dq[0]), .q_valid(dv[0]),
        .rd_busy(dbusy[0]), .rd_done(ddone[0])
    );

    matrix_a_skew_buffer #(.BITS(8), .ROWS(4), .COLS(4), .SKEW(0)) u_dut_flat (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .wr_commit(wr_commit), .wr_ready(dready[1]),
        .rd_start(rd_start), .rd_en(rd_en), .q(dq[1]), .q_valid(dv[1]),
        .rd_busy(dbusy[1]), .rd_done(ddone[1])
    );

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
        end
    endtask

    // ---------------- model: each stream is a precomputed list of frames ----------------
    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0]      v;
        logic            last;
    } frame_t;

    logic [7:0]      mb [2][2][4][4];
    logic [1:0]      mfull [2];
    int              mwp [2], mrp [2], nfr [2], idx [2];
    bit              strm [2];
    frame_t          fr [2][8];
    frame_t          m_f;
    logic [3:0][7:0] eq [2];
    logic [3:0]      ev [2];
    bit              ebusy [2], edone [2];
    bit              m_free, m_ready, m_started = 1'b0;

    function automatic int skw(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int b = 0; b < 2; b++)
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) mb[d][b][r][c] = 8'h00;
                mfull[d] = 2'b00; mwp[d] = 0; mrp[d] = 0; strm[d] = 1'b0;
                eq[d] = '0; ev[d] = '0; ebusy[d] = 1'b0; edone[d] = 1'b0;
            end else begin
                m_free  = 1'b0;
                m_ready = !mfull[d][mwp[d]];
                if (strm[d]) begin
                    if (rd_en) begin
                        if (idx[d] == nfr[d]) begin
                            eq[d] = '0; ev[d] = '0; ebusy[d] = 1'b0; edone[d] = 1'b0;
                            strm[d] = 1'b0; m_free = 1'b1;
                        end else begin
                            eq[d] = fr[d][idx[d]].q; ev[d] = fr[d][idx[d]].v;
                            edone[d] = fr[d][idx[d]].last; idx[d]++;
                        end
                    end
                end else if (rd_start && mfull[d][mrp[d]]) begin
                    nfr[d] = 4 + skw(d) * 3;
                    for (int s = 0; s < nfr[d]; s++) begin
                        m_f = '0;
                        for (int r = 0; r < 4; r++) begin
                            if (s - r * skw(d) >= 0 && s - r * skw(d) < 4) begin
                                m_f.q[r] = mb[d][mrp[d]][r][s - r * skw(d)];
                                m_f.v[r] = 1'b1;
                            end
                        end
                        m_f.last = (s == nfr[d] - 1);
                        fr[d][s] = m_f;
                    end
                    idx[d] = 0; strm[d] = 1'b1; ebusy[d] = 1'b1;
                end
                if (m_ready) begin
                    if (wr_en) mb[d][mwp[d]][wr_row][wr_col] = wr_data;
                    if (wr_commit) begin mfull[d][mwp[d]] = 1'b1; mwp[d] ^= 1; end
                end
                if (m_free) begin mfull[d][mrp[d]] = 1'b0; mrp[d] ^= 1; end
            end
        end
        m_started = 1'b1;
    end

    // ---------------- per-cycle compare on the falling edge ----------------
    int  rises [2] = '{0, 0};
    logic prev_done [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        if (m_started) begin
            for (int d = 0; d < 2; d++) begin
                chk(d, "q",        64'(dq[d]),     64'(eq[d]));
                chk(d, "q_valid",  64'(dv[d]),     64'(ev[d]));
                chk(d, "rd_busy",  64'(dbusy[d]),  64'(ebusy[d]));
                chk(d, "rd_done",  64'(ddone[d]),  64'(edone[d]));
                chk(d, "wr_ready", 64'(dready[d]), 64'(!mfull[d][mwp[d]]));
                if (ddone[d] === 1'b1 && prev_done[d] !== 1'b1) rises[d]++;
                prev_done[d] = ddone[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_commit = 1'b0; rd_start = 1'b0; rd_en = 1'b0;
        wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'd0;
        tick(); tick();
        for (int d = 0; d < 2; d++) begin
            chk(d, "reset_q",        64'(dq[d]),     64'd0);
            chk(d, "reset_q_valid",  64'(dv[d]),     64'd0);
            chk(d, "reset_rd_busy",  64'(dbusy[d]),  64'd0);
            chk(d, "reset_wr_ready", 64'(dready[d]), 64'd1);
        end
        rst = 1'b0;

        // Commit an unwritten bank and stream it: zeros with skewed valids.
        wr_commit = 1'b1; tick(); wr_commit = 1'b0;
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        rd_en = 1'b1; tick();
        chk(0, "zero_step0_q", 64'(dq[0]), 64'd0);
        chk(0, "zero_step0_v", 64'(dv[0]), 64'h1);
        chk(1, "zero_step0_v", 64'(dv[1]), 64'hF);
        repeat (8) tick();
        rd_en = 1'b0;

        // rd_start with no full bank is ignored.
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        chk(0, "start_empty_busy", 64'(dbusy[0]), 64'd0);
        chk(1, "start_empty_busy", 64'(dbusy[1]), 64'd0);

        // Fill A[r][c] = r*4+c+1 and commit.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = 8'(r * 4 + c + 1);
                tick();
            end
        end
        wr_en = 1'b0; wr_commit = 1'b1; tick(); wr_commit = 1'b0;

        fork
            begin : reader
                repeat (7) tick();
                rd_start = 1'b1; tick(); rd_start = 1'b0;
                rd_en = 1'b1;
                tick(); tick(); tick();
                chk(0, "skew_step2_q", 64'(dq[0]), 64'h00_09_06_03);
                chk(0, "skew_step2_v", 64'(dv[0]), 64'b0111);
                tick();
                chk(1, "flat_step3_q",    64'(dq[1]),    64'h10_0C_08_04);
                chk(1, "flat_step3_done", 64'(ddone[1]), 64'd1);
                chk(0, "skew_step3_done", 64'(ddone[0]), 64'd0);
                rd_en = 1'b0;
                repeat (3) tick();
                chk(0, "pause_q_held", 64'(dq[0]), 64'h0D_0A_07_04);
                rd_en = 1'b1; rd_start = 1'b1; tick(); rd_start = 1'b0;
                tick(); tick();
                chk(0, "skew_step6_q",    64'(dq[0]),    64'h10_00_00_00);
                chk(0, "skew_step6_v",    64'(dv[0]),    64'b1000);
                chk(0, "skew_step6_done", 64'(ddone[0]), 64'd1);
                tick();
                rd_en = 1'b0;
                chk(0, "end_busy", 64'(dbusy[0]), 64'd0);
            end
            begin : writer
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        wr_en = 1'b1; wr_row = 2'(r); wr_col = 2'(c); wr_data = 8'(-(r * 4 + c + 1));
                        tick();
                    end
                end
                wr_en = 1'b0; wr_commit = 1'b1; tick();
                chk(0, "both_full_ready", 64'(dready[0]), 64'd0);
                wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 8'h55; tick();
                wr_en = 1'b0; wr_commit = 1'b0;
            end
        join

        // Second bank streams after a fresh rd_start.
        rd_start = 1'b1; tick(); rd_start = 1'b0;
        rd_en = 1'b1; tick();
        chk(0, "neg_step0_q0", 64'(dq[0][0]), 64'hFF);
        chk(1, "neg_step0_q0", 64'(dq[1][0]), 64'hFF);
        tick(); tick();

        // Reset mid-stream aborts without rd_done.
        rst = 1'b1; tick(); rst = 1'b0; rd_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk(d, "midrst_q",        64'(dq[d]),     64'd0);
            chk(d, "midrst_q_valid",  64'(dv[d]),     64'd0);
            chk(d, "midrst_rd_busy",  64'(dbusy[d]),  64'd0);
            chk(d, "midrst_wr_ready", 64'(dready[d]), 64'd1);
        end
        repeat (3) tick();
        chk(0, "done_pulses", 64'(rises[0]), 64'd2);
        chk(1, "done_pulses", 64'(rises[1]), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_a_skew_buffer.md
Name: matrix_a_skew_buffer

Overview:
Double-buffered (ping-pong) staging buffer for the A operand of the systolic matrix multiplier. It holds two ROWS x COLS banks. A host writes elements by row/col into one bank while the other bank streams out column by column, one value per row per step. An optional diagonal skew delays row r by r*SKEW steps, so the output feeds the array's west edge directly.

Parameters:
BITS, 8, signed element width
ROWS, 8, matrix rows = number of output lanes
COLS, 8, matrix columns = stream steps per row
SKEW, 1, 1 = diagonal skew (row r delayed r steps), 0 = all rows aligned

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  write wr_data into write bank at [wr_row][wr_col]
wr_row  in  $clog2(ROWS)  write row index
wr_col  in  $clog2(COLS)  write column index
wr_data  in  BITS signed  element
wr_commit  in  1  mark write bank full; swap write pointer
wr_ready  out  1  write bank is empty and accepts writes/commit
rd_start  in  1  request stream of oldest full bank
rd_en  in  1  advance stream; low = pause/hold
q  out  [ROWS] x BITS signed  per-row output lane
q_valid  out  ROWS  lane r carries a real element
rd_busy  out  1  streaming in progress
rd_done  out  1  high during cycle presenting final step

Behaviour:
- Reset (sync, active-high), clears: both banks' storage to 0, full[1:0]=0, wr_ptr=rd_ptr=0, state IDLE, q=0, q_valid=0, rd_busy=0, rd_done=0, wr_ready=1. Reset mid-stream aborts the stream; no rd_done.
- wr_ready = !full[wr_ptr] (combinational).
- Write: on posedge with wr_en && wr_ready, bank[wr_ptr][wr_row][wr_col] <= wr_data. Writes are ignored when !wr_ready or the index is out of range (row>=ROWS, col>=COLS).
- Commit: wr_commit && wr_ready sets full[wr_ptr] and toggles wr_ptr. It is ignored when !wr_ready. wr_en and wr_commit in the same cycle: the write lands first, then the bank commits.
- Stream length LEN = COLS + SKEW*(ROWS-1). Step counter width $clog2(LEN+1).
- FSM IDLE:
  - rd_start && full[rd_ptr] -> STREAM, step=0, rd_busy=1.
  - rd_start with no full bank is ignored.
- FSM STREAM:
  - q is registered. At each posedge with rd_en, the registers load step s and then s increments. The first rd_en edge after entry loads step 0.
  - Step s: k = s - r*SKEW. If 0<=k<COLS, q[r]=bank[rd_ptr][r][k] and q_valid[r]=1; otherwise q[r]=0 and q_valid[r]=0.
  - rd_en low holds q, q_valid and s unchanged.
  - rd_done=1 while step LEN-1 is presented.
  - The next rd_en edge clears q/q_valid to 0, clears full[rd_ptr], toggles rd_ptr and returns to IDLE. rd_busy falls at the same edge.
  - rd_start while in STREAM is ignored.
- Simultaneous free and commit: a bank freed by the reader and a commit by the writer on the same edge both take effect. wr_ready reflects the freed bank on the following cycle.
- Latency: rd_start at edge t -> step 0 visible after edge t+1 (if rd_en). A back-to-back second bank needs a fresh rd_start in IDLE, so there is a minimum 1 idle cycle between streams.
- Arithmetic: none. Data is passed through bit-exact, and zero fill is signed 0.

Decomposition:
- Package matmul_pkg: BITS/ROWS/COLS defaults, LEN function, state enum (IDLE, STREAM).
- Sub-module matrix_bank: a single ROWS x COLS register bank with sync clear, write port and a combinational read of one element per row at independent column indices.
- This block instantiates two matrix_bank instances plus the ping-pong control, FSM and output registers.

Test Plan:
- Reset zero: ROWS=COLS=4, SKEW=1, commit an unwritten bank after reset, stream -> all 7 steps give q=0 and q_valid asserted per skew pattern. Reset mid-stream -> q=0, q_valid=0, rd_busy=0, wr_ready=1.
- Skewed stream: write A[r][c]=r*4+c+1, commit, rd_start, rd_en=1:
  - step 2 -> q={3,6,9,0}, q_valid=4'b0111.
  - step 6 -> q={0,0,0,16}, q_valid=4'b1000, rd_done=1.
- SKEW=0, same data -> step c gives q[r]=A[r][c]. LEN=4; rd_done on step 3 with q={4,8,12,16}.
- Ping-pong: commit bank0 (values 1..16), write and commit bank1 (negatives -1..-16) while bank0 streams. A third write while both banks are full is ignored (wr_ready=0). After bank0 is done, rd_start streams bank1 and step 0 gives q[0]=-1.
- Pause: drop rd_en for 3 cycles at step 3 -> q/q_valid/rd_done frozen, then resume at step 4. Total active steps = 7.
- Protocol abuse:
  - rd_start with no full bank -> stays IDLE, rd_busy=0.
  - wr_commit when wr_ready=0 -> no change.
  - rd_start during STREAM -> ignored; exactly one rd_done per stream.
